fnd_controller_watch: RTL and testbench
=======================================

FND_CONTROLLER_WATCH -- requirements
Module: fnd_controller_watch

Interface
REQ-001 SHALL have parameter REFRESH_COUNT, default 100_000, which sets the number of clk cycles per digit slot (1 kHz at 100 MHz).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port i_msec, input, 7 bits: centisecond count, 0..99.
REQ-005 SHALL have port i_sec, input, 6 bits: seconds, 0..59.
REQ-006 SHALL have port i_min, input, 6 bits: minutes, 0..59.
REQ-007 SHALL have port i_hour, input, 5 bits: hours, 0..23.
REQ-008 SHALL have port sel_mode, input, 1 bit: 0 = sec:msec view, 1 = hour:min view.
REQ-009 SHALL have port fnd_com, output, 4 bits: active-low digit enables; bit k drives digit k, and digit 0 is the rightmost.
REQ-010 SHALL have port fnd_font, output, 8 bits: active-low segments; bit 7 = dp, bits 6..0 = g..a.

Function
REQ-011 SHALL run a refresh counter 0..REFRESH_COUNT-1 with wrap; when it equals REFRESH_COUNT-1, a registered one-cycle tick SHALL assert on the next cycle.
REQ-012 SHALL hold a 2-bit digit index that advances 3->0->1->2->3 on each edge where tick is high, and holds otherwise.
REQ-013 SHALL capture a frame snapshot of i_msec, i_sec, i_min, i_hour and sel_mode on the same edge where the digit index wraps 3->0.
- Within a frame, every digit SHALL use only snapshot values (no tearing).
REQ-014 SHALL derive digit values from the snapshot:
- mode 0: digit3 = sec/10, digit2 = sec%10, digit1 = msec/10, digit0 = msec%10.
- mode 1: digit3 = hour/10, digit2 = hour%10, digit1 = min/10, digit0 = min%10.
REQ-015 SHALL treat out-of-range inputs as (v/10)%10 and v%10; no error flag.
REQ-016 SHALL register fnd_com and fnd_font on the same edge that updates the digit index; fnd_com SHALL equal ~(1<<index).
REQ-017 SHALL encode digits as 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex, dp off).
REQ-018 SHALL clear dp (bit 7 = 0, lit) only on digit 2, and only when snapshot msec < 50; this gives a 1 Hz colon blink in both modes.
REQ-019 SHALL hold the frame mode until the next wrap when sel_mode changes mid-frame.
REQ-020 SHALL produce exactly one low bit in fnd_com in every cycle after the first tick.

Reset
REQ-021 SHALL set, on reset, refresh counter = 0, tick = 0, digit index = 3, snapshot = 0, fnd_com = 4'b1111 and fnd_font = 8'hFF.
REQ-022 SHALL make the first tick after reset wrap the index to 0, take a snapshot and light digit 0.
REQ-023 SHALL make reset asserted mid-frame blank the outputs on the next edge and restart per REQ-022; reset SHALL take priority over tick.

Structure
REQ-024 SHALL place the 7-segment font constants (digits 0-9 and blank 8'hFF) in shared package fnd_pkg, so that other FND drivers reuse them.
REQ-025 SHALL implement the digit-to-font lookup as a combinational sub-module bcd_to_fnd (4-bit in, 7 bits g..a out); the dp bit is merged in fnd_controller_watch.
REQ-026 SHALL compute /10 and %10 combinationally; no multi-cycle divider.

Verification (REFRESH_COUNT = 4)
REQ-027 Reset held 3 cycles, then released, with sec=12 msec=34 mode=0 -> fnd_com=1111 and font=FF until the first tick; then the digit 0 slot shows fnd_com=1110, font=99 ("4"); later slots show digit1 = B0 ("3"), digit2 = A4 ("2") with dp lit = 24, and digit3 = F9 ("1"), each slot lasting 4 cycles.
REQ-028 mode=1, hour=23, min=59, msec=75 -> digits 3..0 = A4, B0, 92, 90; digit2 dp off (font B0).
REQ-029 msec changed from 10 to 60 while digit index = 1 -> digits 2 and 3 of the current frame are unchanged; the next frame's digit 2 has dp off.
REQ-030 sel_mode toggled 0->1 at index 2 -> digit 3 still shows the sec tens; the hour:min view starts at the next digit 0.
REQ-031 reset pulsed for 1 cycle while index = 2 -> outputs are FF/1111 on the next edge; digit 0 reappears after the first tick (REFRESH_COUNT+1 cycles after release); fnd_com is never all-zero.
REQ-032 Out-of-range i_msec=127 -> digit1 = A4 ("2"), digit0 = F8 ("7").

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared 7-segment font constants for the FND display drivers.
// Fonts are active-low {dp, g..a}; every constant has dp off.
package fnd_pkg;

    localparam logic [7:0] FONT_0     = 8'hC0;
    localparam logic [7:0] FONT_1     = 8'hF9;
    localparam logic [7:0] FONT_2     = 8'hA4;
    localparam logic [7:0] FONT_3     = 8'hB0;
    localparam logic [7:0] FONT_4     = 8'h99;
    localparam logic [7:0] FONT_5     = 8'h92;
    localparam logic [7:0] FONT_6     = 8'h82;
    localparam logic [7:0] FONT_7     = 8'hF8;
    localparam logic [7:0] FONT_8     = 8'h80;
    localparam logic [7:0] FONT_9     = 8'h90;
    localparam logic [7:0] FONT_BLANK = 8'hFF;

    localparam logic [1:0] DIGIT_LAST = 2'd3;

endpackage

// File: rtl/bcd_to_fnd.sv
// Combinational decimal digit to active-low g..a segment lookup.
module bcd_to_fnd
    import fnd_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = FONT_BLANK[6:0];
        case (i_bcd)
            4'd0:    o_seg = FONT_0[6:0];
            4'd1:    o_seg = FONT_1[6:0];
            4'd2:    o_seg = FONT_2[6:0];
            4'd3:    o_seg = FONT_3[6:0];
            4'd4:    o_seg = FONT_4[6:0];
            4'd5:    o_seg = FONT_5[6:0];
            4'd6:    o_seg = FONT_6[6:0];
            4'd7:    o_seg = FONT_7[6:0];
            4'd8:    o_seg = FONT_8[6:0];
            4'd9:    o_seg = FONT_9[6:0];
            default: o_seg = FONT_BLANK[6:0];
        endcase
    end

endmodule

// File: rtl/fnd_controller_watch.sv
// Four-digit multiplexed FND driver for a stopwatch/clock: sec:msec or hour:min
// view, with a tear-free snapshot taken at each frame start and a 1 Hz dp blink.
module fnd_controller_watch
    import fnd_pkg::*;
#(
    parameter int REFRESH_COUNT = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] i_msec,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    input  logic [4:0] i_hour,
    input  logic       sel_mode,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_font
);

    localparam int CW = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_COUNT - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;
    logic [1:0]    r_idx;
    logic [6:0]    r_msec;
    logic [5:0]    r_sec;
    logic [5:0]    r_min;
    logic [4:0]    r_hour;
    logic          r_mode;

    logic          w_wrap;
    logic [1:0]    w_idx_next;
    logic [6:0]    w_msec;
    logic [5:0]    w_sec;
    logic [5:0]    w_min;
    logic [4:0]    w_hour;
    logic          w_mode;
    logic [6:0]    w_hi;
    logic [6:0]    w_lo;
    logic [3:0]    w_digit;
    logic          w_dp;
    logic [6:0]    w_seg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            r_tick <= (r_cnt == CNT_LAST);
        end
    end

    assign w_wrap     = r_tick && (r_idx == DIGIT_LAST);
    assign w_idx_next = r_idx + 2'd1;

    // The digit lit on the wrap edge must already see the values being captured.
    assign w_msec = w_wrap ? i_msec   : r_msec;
    assign w_sec  = w_wrap ? i_sec    : r_sec;
    assign w_min  = w_wrap ? i_min    : r_min;
    assign w_hour = w_wrap ? i_hour   : r_hour;
    assign w_mode = w_wrap ? sel_mode : r_mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_msec <= '0;
            r_sec  <= '0;
            r_min  <= '0;
            r_hour <= '0;
            r_mode <= 1'b0;
        end else if (w_wrap) begin
            r_msec <= i_msec;
            r_sec  <= i_sec;
            r_min  <= i_min;
            r_hour <= i_hour;
            r_mode <= sel_mode;
        end
    end

    assign w_hi = w_mode ? {2'b00, w_hour} : {1'b0, w_sec};
    assign w_lo = w_mode ? {1'b0, w_min}   : w_msec;

    always_comb begin
        w_digit = 4'd0;
        case (w_idx_next)
            2'd0: w_digit = 4'(w_lo % 7'd10);
            2'd1: w_digit = 4'((w_lo / 7'd10) % 7'd10);
            2'd2: w_digit = 4'(w_hi % 7'd10);
            2'd3: w_digit = 4'((w_hi / 7'd10) % 7'd10);
            default: w_digit = 4'd0;
        endcase
    end

    assign w_dp = !((w_idx_next == 2'd2) && (w_msec < 7'd50));

    bcd_to_fnd u_bcd_to_fnd (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx    <= DIGIT_LAST;
            fnd_com  <= 4'b1111;
            fnd_font <= FONT_BLANK;
        end else if (r_tick) begin
            r_idx    <= w_idx_next;
            fnd_com  <= ~(4'b0001 << w_idx_next);
            fnd_font <= {w_dp, w_seg};
        end
    end

endmodule

// File: tb/tb_fnd_controller_watch.sv
// Directed bench for fnd_controller_watch with REFRESH_COUNT = 4.
module tb_fnd_controller_watch;

    logic       clk;
    logic       reset;
    logic [6:0] i_msec;
    logic [5:0] i_sec;
    logic [5:0] i_min;
    logic [4:0] i_hour;
    logic       sel_mode;
    logic [3:0] fnd_com;
    logic [7:0] fnd_font;

    int n_checks = 0;
    int n_err    = 0;

    logic [11:0] exp_q[$];
    logic [7:0]  font_ref [10];

    fnd_controller_watch #(.REFRESH_COUNT(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_msec   (i_msec),
        .i_sec    (i_sec),
        .i_min    (i_min),
        .i_hour   (i_hour),
        .sel_mode (sel_mode),
        .fnd_com  (fnd_com),
        .fnd_font (fnd_font)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check("com_nonzero", {11'd0, fnd_com != 4'b0000}, 12'd1);
    endtask

    task automatic blank_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("blank", {fnd_com, fnd_font}, 12'hFFF);
        end
    endtask

    // Expected {com, font} for digits 0..3 of a frame built from these values.
    task automatic expect_frame(input int sec, input int msec, input int min,
                                input int hour, input bit mode);
        int hi, lo, d;
        logic [7:0] f;
        hi = mode ? hour : sec;
        lo = mode ? min  : msec;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: d = lo % 10;
                1: d = (lo / 10) % 10;
                2: d = hi % 10;
                default: d = (hi / 10) % 10;
            endcase
            f = font_ref[d];
            if (k == 2 && msec < 50) f[7] = 1'b0;
            exp_q.push_back({~(4'b0001 << k), f});
        end
    endtask

    task automatic pop_check(input string tag, output logic [11:0] e);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $error("FAIL %s: observed=%h expected=<empty queue>", tag, {fnd_com, fnd_font});
            e = 12'hxxx;
        end else begin
            e = exp_q.pop_front();
            check(tag, {fnd_com, fnd_font}, e);
        end
    endtask

    task automatic check_slot(input string tag);
        logic [11:0] e;
        step();
        pop_check(tag, e);
        for (int i = 0; i < 3; i++) begin
            step();
            check({tag, "_hold"}, {fnd_com, fnd_font}, e);
        end
    endtask

    task automatic check_frame(input string tag);
        check_slot({tag, "_d0"});
        check_slot({tag, "_d1"});
        check_slot({tag, "_d2"});
        check_slot({tag, "_d3"});
    endtask

    initial begin
        logic [11:0] e;
        font_ref = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                     8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

        // Reset held 3 cycles, then blank until the first tick.
        reset = 1'b1; sel_mode = 1'b0;
        i_sec = 6'd12; i_msec = 7'd34; i_min = 6'd0; i_hour = 5'd0;
        repeat (3) @(negedge clk);
        check("reset_state", {fnd_com, fnd_font}, 12'hFFF);
        reset = 1'b0;
        expect_frame(12, 34, 0, 0, 1'b0);
        blank_steps(4);
        check_frame("f1");

        // msec moves from 10 to 60 while index 1 is showing.
        i_sec = 6'd35; i_msec = 7'd10;
        expect_frame(35, 10, 0, 0, 1'b0);
        check_slot("f2_d0");
        check_slot("f2_d1");
        i_msec = 7'd60;
        check_slot("f2_d2");
        check_slot("f2_d3");

        // Mode switch at index 2 only takes effect at the next digit 0.
        expect_frame(35, 60, 0, 0, 1'b0);
        check_slot("f3_d0");
        check_slot("f3_d1");
        check_slot("f3_d2");
        sel_mode = 1'b1; i_hour = 5'd23; i_min = 6'd59; i_msec = 7'd75;
        check_slot("f3_d3");

        expect_frame(35, 75, 59, 23, 1'b1);
        check_frame("f4_hm");

        // Out-of-range msec.
        sel_mode = 1'b0; i_sec = 6'd42; i_msec = 7'd127;
        expect_frame(42, 127, 59, 23, 1'b0);
        check_frame("f5_oor");

        // Reset pulse while index 2 is showing.
        i_sec = 6'd59; i_msec = 7'd0;
        expect_frame(59, 0, 59, 23, 1'b0);
        check_slot("f6_d0");
        check_slot("f6_d1");
        step();
        pop_check("f6_d2", e);
        void'(exp_q.pop_back());
        reset = 1'b1;
        step();
        check("midreset_blank", {fnd_com, fnd_font}, 12'hFFF);
        reset = 1'b0;
        blank_steps(4);
        expect_frame(59, 0, 59, 23, 1'b0);
        check_frame("f7_after_reset");

        check("queue_drained", 12'(exp_q.size()), 12'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
